// File: rtl/apb_uart_pkg.sv
// Shared register map, STATUS bit positions and TX state encoding for the APB UART transmitter.
package apb_uart_pkg;

  localparam logic [3:0] REG_TXDATA  = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_BAUDDIV = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_COUNT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_t;

endpackage

// File: rtl/apb_uart_tx_slave_if.sv
// APB bus bundle between the interconnect initiator and the UART TX responder.
interface apb_uart_tx_slave_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic            psel;
  logic            penable;
  logic            pready;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   rdata;

  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  pready, rdata
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output pready, rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push is ignored when full, pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int PW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx_slave.sv
// APB responder with TX FIFO, programmable baud divider and 8N1 serialiser.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); chains straight into START if more data is queued
module apb_uart_tx_slave
  import apb_uart_pkg::*;
#(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 434
) (
  input  logic                clk_i,
  input  logic                reset_i,
  apb_uart_tx_slave_if.slave  s_apb,
  output logic                uart_tx_o,
  output logic                tx_irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [3:0]      offset;
  logic            setup_ph;
  logic            access_ph;
  logic            wr_txdata;
  logic            wr_bauddiv;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [7:0]      fifo_rd;
  logic [15:0]     baud_div;
  logic [15:0]     baud_next;
  logic [15:0]     baud_cnt;
  logic            bit_end;
  tx_state_t       state;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            tx_q;
  logic [DW-1:0]   status_word;
  logic [DW-1:0]   rd_mux;
  logic [DW-1:0]   rdata_q;
  logic            unused_ok;

  assign paddr  = s_apb.paddr;
  assign pwdata = s_apb.pwdata;
  assign pstrb  = s_apb.pstrb;
  assign offset = paddr[3:0];

  assign setup_ph   = s_apb.psel & ~s_apb.penable;
  assign access_ph  = s_apb.psel & s_apb.penable;
  assign wr_txdata  = access_ph & s_apb.pwrite & (offset == REG_TXDATA);
  assign wr_bauddiv = access_ph & s_apb.pwrite & (offset == REG_BAUDDIV);

  // Only a TXDATA write against a full FIFO stalls; full comes from the registered count.
  assign s_apb.pready = ~(wr_txdata & full);
  assign push         = wr_txdata & ~full & pstrb[0];

  assign bit_end = (baud_cnt == 16'd0);
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

  assign uart_tx_o   = tx_q;
  assign tx_irq_o    = empty & (state == IDLE);
  assign s_apb.rdata = rdata_q;

  assign unused_ok = ^{paddr[AW-1:4], pwdata[DW-1:16], pstrb[DW/8-1:2]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .wr_data (pwdata[7:0]),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // STATUS word assembled from live FIFO/FSM state.
  always_comb begin
    status_word                  = '0;
    status_word[STAT_BUSY]       = (state != IDLE);
    status_word[STAT_FULL]       = full;
    status_word[STAT_EMPTY]      = empty;
    status_word[STAT_COUNT +: CW] = count;
  end

  // Read mux; TXDATA and unmapped offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_STATUS:  rd_mux = status_word;
      REG_BAUDDIV: rd_mux[15:0] = baud_div;
      default:     rd_mux = '0;
    endcase
  end

  // Byte-lane merge of a BAUDDIV write with the current value.
  always_comb begin
    baud_next       = baud_div;
    if (pstrb[0]) baud_next[7:0]  = pwdata[7:0];
    if (pstrb[1]) baud_next[15:8] = pwdata[15:8];
  end

  // Read data is captured in the setup phase so the access phase completes without wait states.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (setup_ph) begin
      rdata_q <= s_apb.pwrite ? '0 : rd_mux;
    end
  end

  // BAUDDIV register; a divider of zero would stall the bit timer, so it is clamped to one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      baud_div <= 16'(BAUD_DIV_RST);
    end else if (wr_bauddiv) begin
      baud_div <= (baud_next == 16'd0) ? 16'd1 : baud_next;
    end
  end

  // TX FSM; the bit timer reloads from BAUDDIV only at bit boundaries so a new divider never truncates a bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            state    <= START;
            shift    <= fifo_rd;
            baud_cnt <= baud_div - 16'd1;
            tx_q     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            tx_q     <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= 3'd0;
            baud_cnt <= baud_div - 16'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= baud_div - 16'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              state    <= START;
              shift    <= fifo_rd;
              baud_cnt <= baud_div - 16'd1;
              tx_q     <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// Directed bench for apb_uart_tx_slave: register access, 8N1 framing, FIFO back-pressure and reset abort.
module tb_apb_uart_tx_slave;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_uart_tx_slave_if #(.AW(12), .DW(32)) apb ();

  apb_uart_tx_slave #(
    .AW           (12),
    .DW           (32),
    .FIFO_DEPTH   (8),
    .BAUD_DIV_RST (434)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .s_apb     (apb),
    .uart_tx_o (tx),
    .tx_irq_o  (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line levels for one 8N1 frame at 4 clocks per bit.
  function automatic logic [39:0] frame4(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int waits);
    waits = 0;
    apb.paddr   = a;
    apb.pwdata  = d;
    apb.pstrb   = s;
    apb.pwrite  = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #1;
    while (!apb.pready && waits < 20000) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!apb.pready) check("pready_timeout", apb.pready, 1'b1);
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    apb.paddr   = a;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #1;
    d = apb.rdata;
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  // Write one byte at BAUDDIV=4 and compare the 40-clock frame that follows.
  task automatic send_and_check(input logic [7:0] b, input string tag);
    logic [39:0] got;
    int w;
    apb_write(12'h000, {24'h0, b}, 4'b0001, w);
    check({tag, "_pre_start"}, tx, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      got[i] = tx;
      if (i == 39) check({tag, "_irq_in_stop"}, irq, 1'b0);
      @(posedge clk); #1;
    end
    check({tag, "_frame"}, got, frame4(b));
    check({tag, "_irq_after"}, irq, 1'b1);
    check({tag, "_tx_after"}, tx, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [79:0] b2b;
    int w;
    int wsum;
    int n;

    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b1);
    check("rst_rdata", apb.rdata, 32'h0);
    apb_read(12'h004, rd);
    check("rst_status", rd, 32'h0000_0004);
    apb_read(12'h008, rd);
    check("rst_bauddiv", rd, 32'd434);

    // Single frame
    apb_write(12'h008, 32'd4, 4'b0011, w);
    apb_read(12'h008, rd);
    check("bauddiv_4", rd, 32'd4);
    send_and_check(8'h55, "f55");

    // Two bytes back to back: no idle gap between frames
    fork
      begin
        apb_write(12'h000, 32'hA5, 4'b0001, w);
        apb_write(12'h000, 32'h3C, 4'b0001, w);
      end
      begin
        n = 0;
        while (tx && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("b2b_start_seen", tx, 1'b0);
        for (int i = 0; i < 80; i++) begin
          b2b[i] = tx;
          @(posedge clk); #1;
        end
      end
    join
    check("b2b_frame_a5", b2b[39:0], frame4(8'hA5));
    check("b2b_frame_3c", b2b[79:40], frame4(8'h3C));
    check("b2b_irq_after", irq, 1'b1);

    // FIFO back-pressure at BAUDDIV=1000
    apb_write(12'h008, 32'd1000, 4'b0011, w);
    wsum = 0;
    for (int i = 0; i < 9; i++) begin
      apb_write(12'h000, 32'h10 + i, 4'b0001, w);
      wsum += w;
    end
    check("fill_no_wait", wsum, 0);
    apb_write(12'h000, 32'h99, 4'b0001, w);
    check("full_stall_cycles", w, 9984);
    apb_read(12'h004, rd);
    check("full_status", rd, 32'h0000_0803);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    apb_read(12'h004, rd);
    check("rst_flush_status", rd, 32'h0000_0004);

    // Strobes and BAUDDIV clamping
    apb_write(12'h000, 32'h77, 4'b0000, w);
    check("nostrb_wait", w, 0);
    apb_read(12'h004, rd);
    check("nostrb_status", rd, 32'h0000_0004);
    check("nostrb_irq", irq, 1'b1);
    apb_write(12'h008, 32'h0, 4'b0011, w);
    apb_read(12'h008, rd);
    check("bauddiv_zero", rd, 32'd1);
    apb_write(12'h008, 32'h1234, 4'b0011, w);
    apb_write(12'h008, 32'hFF56, 4'b0001, w);
    apb_read(12'h008, rd);
    check("bauddiv_lane0", rd, 32'h1256);
    apb_write(12'h008, 32'hAB00, 4'b0010, w);
    apb_read(12'h008, rd);
    check("bauddiv_lane1", rd, 32'hAB56);
    apb_write(12'h00C, 32'hFFFF, 4'b1111, w);
    apb_read(12'h00C, rd);
    check("unmapped_read", rd, 32'h0);
    apb_read(12'h008, rd);
    check("unmapped_wr_ignored", rd, 32'hAB56);
    apb_read(12'h000, rd);
    check("txdata_read", rd, 32'h0);
    apb_read(12'h104, rd);
    check("status_alias", rd, 32'h0000_0004);

    // Reset during DATA bit 3 of 0xC3
    apb_write(12'h008, 32'd4, 4'b0011, w);
    apb_write(12'h000, 32'hC3, 4'b0001, w);
    repeat (18) begin
      @(posedge clk); #1;
    end
    check("mid_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_irq", irq, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    apb_read(12'h004, rd);
    check("abort_status", rd, 32'h0000_0004);
    apb_read(12'h008, rd);
    check("abort_bauddiv", rd, 32'd434);
    apb_write(12'h008, 32'd4, 4'b0011, w);
    send_and_check(8'h96, "f96");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
